// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result-bus protocol: opcodes, data width and
// the sequencer state encoding.
package fpu_pkg;

    localparam int FP_W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SQRT = 4'd4;
    localparam logic [3:0] OP_ABS  = 4'd5;
    localparam logic [3:0] OP_NEG  = 4'd6;
    localparam logic [3:0] OP_CMP  = 4'd7;
    localparam logic [3:0] OP_CVT  = 4'd8;
    localparam logic [3:0] OP_MOV  = 4'd9;
    localparam logic [3:0] OP_NOP  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fpu_op_sequencer.sv
// Issues one FPU request at a time onto the shared op-unit bus, waits for the
// selected unit to settle, then returns the sampled result bus as a response.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int NUM_OPS     = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [FP_W-1:0] req_a,
    input  logic [FP_W-1:0] req_b,
    output logic [3:0]      bus_operation,
    output logic [FP_W-1:0] bus_a,
    output logic [FP_W-1:0] bus_b,
    input  logic [FP_W-1:0] bus_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [FP_W-1:0] rsp_data,
    output logic            rsp_err
);

    localparam logic [4:0] NUM_OPS_W = 5'(NUM_OPS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. req_ready depends only on state; rsp_valid, once raised, stays
    // high with rsp_data/rsp_err stable until the edge where rsp_ready is seen.
    seq_state_t      state, state_n;
    logic [3:0]      counter, counter_n;
    logic [3:0]      op_n;
    logic [FP_W-1:0] a_n, b_n;
    logic            rsp_valid_n, rsp_err_n;
    logic [FP_W-1:0] rsp_data_n;
    logic            op_legal;

    assign req_ready = (state == ST_IDLE);
    assign op_legal  = ({1'b0, req_op} < NUM_OPS_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            counter       <= 4'd0;
            bus_operation <= OP_NOP;
            bus_a         <= '0;
            bus_b         <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            state         <= state_n;
            counter       <= counter_n;
            bus_operation <= op_n;
            bus_a         <= a_n;
            bus_b         <= b_n;
            rsp_valid     <= rsp_valid_n;
            rsp_data      <= rsp_data_n;
            rsp_err       <= rsp_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        counter_n   = counter;
        op_n        = bus_operation;
        a_n         = bus_a;
        b_n         = bus_b;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (op_legal) begin
                        a_n       = req_a;
                        b_n       = req_b;
                        op_n      = req_op;
                        counter_n = WAIT_LOAD;
                        state_n   = ST_BUSY;
                    end else begin
                        // Rejected codes never reach the bus; answer straight away.
                        rsp_data_n  = '0;
                        rsp_err_n   = 1'b1;
                        rsp_valid_n = 1'b1;
                        state_n     = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (counter != 4'd0) begin
                    counter_n = counter - 4'd1;
                end else begin
                    rsp_data_n  = bus_result;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    op_n        = OP_NOP;
                    state_n     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
